cache_2way_wb: RTL and testbench
================================

Name: cache_2way_wb

Overview:
Two-way set-associative, write-back, write-allocate cache with a single-entry CPU port and a block-wide memory port. It is the parametrised successor to the direct-mapped WB cache and sits between CPU load/store logic and the memory controller. It adds a selectable block/index geometry, per-set LRU replacement, block-aligned memory addressing with the correct victim address on writeback, and saturating hit/miss counters.

Parameters:
ADDR_W, 32, address width
WORD_W, 32, CPU word width; power of 2, at least 8
BLK_WORDS, 4, words per block; power of 2, at least 2
INDEX_W, 8, set index bits; 2^INDEX_W sets of 2 ways
CNT_W, 16, hit/miss counter width
Derived values:
- BLK_W = WORD_W*BLK_WORDS
- WOFF_W = log2(BLK_WORDS)
- BOFF_W = WOFF_W + log2(WORD_W/8)
- TAG_W = ADDR_W - INDEX_W - BOFF_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
cpu_req_vld  in  1  request valid; held until cpu_done
cpu_req_wen  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address
cpu_wr_data  in  WORD_W  write word
cpu_rd_data  out  WORD_W  read word; valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
mem_req_vld  out  1  memory request; held until mem_req_done
mem_req_wen  out  1  1=writeback, 0=block read
mem_addr  out  ADDR_W  block-aligned address (low BOFF_W bits 0)
mem_wr_data  out  BLK_W  victim block
mem_rd_data  in  BLK_W  fill block; sampled with mem_req_done
mem_req_done  in  1  one-cycle pulse; ignored when mem_req_vld=0
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Clock is clk. Reset rst is synchronous and active-low. One clock domain.
- Reset at any edge with rst=0:
  - state=IDLE; all valid, dirty and LRU bits cleared.
  - All outputs 0, including the counters.
  - Tag and data arrays are not reset.
- Reset mid-operation: any outstanding memory transaction is abandoned and mem_req_vld is 0 after that edge.
- Address split: tag = addr[ADDR_W-1 -: TAG_W]; index = addr[BOFF_W +: INDEX_W]; word = addr[BOFF_W-1 -: WOFF_W]. Byte-offset bits are ignored.
- IDLE:
  - Accepts when cpu_req_vld=1 and cpu_done=0.
  - Latches addr, wen and wr_data into request registers, then goes to CMP_TAG.
  - Later changes on the CPU inputs have no effect on the accepted request.
- CMP_TAG, hit (valid && tag equal in one way):
  - At this edge: cpu_done<=1; cpu_rd_data<=selected word (pre-write data on a write).
  - A write merges cpu_wr_data into the addressed word and sets dirty.
  - LRU[set] <= the other way; hit_cnt increments; next state IDLE.
- Hit latency: accept edge E0, cpu_done high in the cycle after E1, next accept possible at E2.
- CMP_TAG, miss:
  - miss_cnt increments only on the first compare of a request, not on the post-fill re-compare.
  - Victim = the first invalid way (way0 before way1), else way LRU[set].
  - Victim valid and dirty -> WB; otherwise -> ALLOC.
- WB:
  - mem_req_vld=1, mem_req_wen=1, mem_addr={victim_tag, index, 0}, mem_wr_data=victim block.
  - On mem_req_done, mem_req_vld drops for exactly one cycle, then ALLOC.
- ALLOC:
  - mem_req_vld=1, mem_req_wen=0, mem_addr={req_tag, index, 0}.
  - On mem_req_done: write mem_rd_data into the victim way and set tag, valid=1, dirty=0; mem_req_vld<=0; then CMP_TAG.
  - The re-compare hits, applies the write (write-allocate) and completes as a normal hit.
- mem_req_vld, mem_req_wen, mem_addr and mem_wr_data stay stable while a request is outstanding.
- Counters saturate at all-ones and never wrap.
- Invariant: no set holds the same valid tag in both ways (assertion).

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, CMP_TAG, WB, ALLOC};
  - clog2-based width functions (WOFF_W, BOFF_W, TAG_W, BLK_W);
  - a word-merge function (block, word index, word) -> block.
- One sub-module, cache_2way_tag_array, holds the per-way tag RAMs, the valid/dirty/LRU flop arrays with reset clear, hit/way detection and victim selection.
- Data RAMs and the FSM stay in the top level.

Test Plan:
(Default parameters: BOFF_W=4, TAG_W=20.)
1. Reset, then read 0x0000_1238; memory returns block 0x4444_4444_3333_3333_2222_2222_1111_1111 -> one ALLOC at mem_addr 0x0000_1230, cpu_rd_data=0x3333_3333, miss_cnt=1. Re-read the same address -> cpu_done 2 edges after accept, no mem_req_vld, hit_cnt=1.
2. Write 0xDEADBEEF to 0x0000_1234 (hit), read 0x0001_1234 (fills way1), read 0x0002_1234 -> WB at mem_addr 0x0000_1230 with word1=0xDEADBEEF, one-cycle vld gap, then ALLOC at 0x0002_1230.
3. Fill A=0x0000_1230 and B=0x0001_1230, read A, read C=0x0002_1230 -> B evicted with no WB (clean); a following read of A hits.
4. Cold write 0x12345678 to 0x0000_5008 -> ALLOC 0x0000_5000, merge into word2, dirty=1. Read 0x0000_5008 returns 0x12345678 with no memory traffic.
5. Drop rst low for one cycle while in ALLOC -> mem_req_vld=0 after that edge, counters 0. A read of a previously cached address misses.
6. CNT_W=4, 20 hits -> hit_cnt=15, then holds at 15.

Source files
------------

// File: rtl/cache_2way_wb_pkg.sv
// Shared state encoding and geometry/merge helpers for the two-way write-back cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP_TAG = 2'd1,
        WB      = 2'd2,
        ALLOC   = 2'd3
    } state_e;

    localparam int MAX_BLK_W  = 2048;
    localparam int MAX_WORD_W = 128;

    function automatic int woff_w(input int blk_words);
        return $clog2(blk_words);
    endfunction

    function automatic int boff_w(input int word_w, input int blk_words);
        return $clog2(blk_words) + $clog2(word_w / 8);
    endfunction

    function automatic int tag_w(input int addr_w, input int index_w, input int word_w,
                                 input int blk_words);
        return addr_w - index_w - boff_w(word_w, blk_words);
    endfunction

    function automatic int blk_w(input int word_w, input int blk_words);
        return word_w * blk_words;
    endfunction

    // Callers widen to the maximum sizes and truncate the result back to their geometry.
    function automatic logic [MAX_BLK_W-1:0] merge_word(input logic [MAX_BLK_W-1:0] blk,
                                                        input int widx, input int word_w,
                                                        input logic [MAX_WORD_W-1:0] w);
        logic [MAX_BLK_W-1:0] r;
        r = blk;
        for (int b = 0; b < MAX_WORD_W; b++) begin
            if (b < word_w) r[widx*word_w + b] = w[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_2way_wb_if.sv
// CPU-side and memory-side bus bundles for the two-way write-back cache.
interface cache_cpu_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              cpu_req_vld;
    logic              cpu_req_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wr_data;
    logic [WORD_W-1:0] cpu_rd_data;
    logic              cpu_done;

    modport master (output cpu_req_vld, cpu_req_wen, cpu_addr, cpu_wr_data,
                    input  cpu_rd_data, cpu_done);
    modport slave  (input  cpu_req_vld, cpu_req_wen, cpu_addr, cpu_wr_data,
                    output cpu_rd_data, cpu_done);
endinterface

interface cache_mem_if #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 128
);
    logic              mem_req_vld;
    logic              mem_req_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wr_data;
    logic [BLK_W-1:0]  mem_rd_data;
    logic              mem_req_done;

    modport master (output mem_req_vld, mem_req_wen, mem_addr, mem_wr_data,
                    input  mem_rd_data, mem_req_done);
    modport slave  (input  mem_req_vld, mem_req_wen, mem_addr, mem_wr_data,
                    output mem_rd_data, mem_req_done);
endinterface

// File: rtl/cache_2way_wb_tag_array.sv
// Tag RAMs plus valid/dirty/LRU state for both ways; hit detection and victim choice.
module cache_2way_tag_array #(
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic               hit_way,
    output logic               victim_way,
    output logic               victim_dirty,
    output logic [TAG_W-1:0]   victim_tag,
    input  logic               upd_en,
    input  logic               upd_way,
    input  logic               upd_dirty,
    input  logic               fill_en,
    input  logic               fill_way
);
    localparam int SETS = 1 << INDEX_W;

    logic [TAG_W-1:0] tags0 [SETS];
    logic [TAG_W-1:0] tags1 [SETS];
    logic [SETS-1:0]  val0, val1, dty0, dty1, lru;
    logic             h0, h1;

    assign h0      = val0[idx] && (tags0[idx] == tag);
    assign h1      = val1[idx] && (tags1[idx] == tag);
    assign hit     = h0 | h1;
    assign hit_way = h1;

    // lru[set] names the way to evict next.
    always_comb begin
        victim_way = lru[idx];
        if (!val0[idx])      victim_way = 1'b0;
        else if (!val1[idx]) victim_way = 1'b1;
    end

    assign victim_tag   = victim_way ? tags1[idx] : tags0[idx];
    assign victim_dirty = victim_way ? (val1[idx] & dty1[idx]) : (val0[idx] & dty0[idx]);

    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (fill_way) tags1[idx] <= tag;
            else          tags0[idx] <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            val0 <= '0;
            val1 <= '0;
            dty0 <= '0;
            dty1 <= '0;
            lru  <= '0;
        end else begin
            if (fill_en) begin
                if (fill_way) begin
                    val1[idx] <= 1'b1;
                    dty1[idx] <= 1'b0;
                end else begin
                    val0[idx] <= 1'b1;
                    dty0[idx] <= 1'b0;
                end
            end
            if (upd_en) begin
                lru[idx] <= ~upd_way;
                if (upd_dirty) begin
                    if (upd_way) dty1[idx] <= 1'b1;
                    else         dty0[idx] <= 1'b1;
                end
            end
        end
    end

    a_no_dup_tag: assert property (@(posedge clk) disable iff (!rst)
        !(val0[idx] && val1[idx] && (tags0[idx] == tags1[idx])));

endmodule

// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back, write-allocate cache: data RAMs and control FSM.
//   state   | meaning
//   IDLE    | waiting for a CPU request
//   CMP_TAG | tag compare; hit completes, miss picks a victim
//   WB      | writing the dirty victim block back to memory
//   ALLOC   | fetching the requested block into the victim way
module cache_2way_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 4,
    parameter int INDEX_W   = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    cache_cpu_if.slave       cpu,
    cache_mem_if.master      mem,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int WOFF_W = woff_w(BLK_WORDS);
    localparam int BOFF_W = boff_w(WORD_W, BLK_WORDS);
    localparam int TAG_W  = tag_w(ADDR_W, INDEX_W, WORD_W, BLK_WORDS);
    localparam int BLK_W  = blk_w(WORD_W, BLK_WORDS);
    localparam int SETS   = 1 << INDEX_W;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CMP   = CMP_TAG;
    localparam logic [1:0] ST_WB    = WB;
    localparam logic [1:0] ST_ALLOC = ALLOC;

    logic [1:0]        state;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [WORD_W-1:0] req_wdata;
    logic              first_cmp;
    logic              vict_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [WOFF_W-1:0]  req_word;
    logic               unused_addr;

    logic [BLK_W-1:0] data0 [SETS];
    logic [BLK_W-1:0] data1 [SETS];
    logic [BLK_W-1:0] blk0, blk1, hit_blk, merged;
    logic [WORD_W-1:0] rd_word;

    logic             hit, hit_way, victim_way, victim_dirty;
    logic [TAG_W-1:0] victim_tag;
    logic             do_hit, do_fill;

    assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx     = req_addr[BOFF_W +: INDEX_W];
    assign req_word    = req_addr[BOFF_W-1 -: WOFF_W];
    assign unused_addr = ^req_addr;

    assign blk0    = data0[req_idx];
    assign blk1    = data1[req_idx];
    assign hit_blk = hit_way ? blk1 : blk0;
    assign rd_word = hit_blk[req_word*WORD_W +: WORD_W];
    assign merged  = BLK_W'(merge_word(MAX_BLK_W'(hit_blk), int'(req_word), WORD_W,
                                       MAX_WORD_W'(req_wdata)));

    assign do_hit  = (state == ST_CMP) && hit;
    assign do_fill = (state == ST_ALLOC) && mem.mem_req_vld && mem.mem_req_done;

    cache_2way_tag_array #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_tags (
        .clk          (clk),
        .rst          (rst),
        .idx          (req_idx),
        .tag          (req_tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .upd_en       (do_hit),
        .upd_way      (hit_way),
        .upd_dirty    (req_wen),
        .fill_en      (do_fill),
        .fill_way     (vict_q)
    );

    always_ff @(posedge clk) begin
        if (do_fill) begin
            if (vict_q) data1[req_idx] <= mem.mem_rd_data;
            else        data0[req_idx] <= mem.mem_rd_data;
        end else if (do_hit && req_wen) begin
            if (hit_way) data1[req_idx] <= merged;
            else         data0[req_idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_IDLE;
            req_addr        <= '0;
            req_wen         <= 1'b0;
            req_wdata       <= '0;
            first_cmp       <= 1'b0;
            vict_q          <= 1'b0;
            cpu.cpu_done    <= 1'b0;
            cpu.cpu_rd_data <= '0;
            mem.mem_req_vld <= 1'b0;
            mem.mem_req_wen <= 1'b0;
            mem.mem_addr    <= '0;
            mem.mem_wr_data <= '0;
            hit_cnt         <= '0;
            miss_cnt        <= '0;
        end else begin
            cpu.cpu_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu.cpu_req_vld && !cpu.cpu_done) begin
                        req_addr  <= cpu.cpu_addr;
                        req_wen   <= cpu.cpu_req_wen;
                        req_wdata <= cpu.cpu_wr_data;
                        first_cmp <= 1'b1;
                        state     <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    // Both counters only count the first compare of a request.
                    if (hit) begin
                        cpu.cpu_done    <= 1'b1;
                        cpu.cpu_rd_data <= rd_word;
                        if (first_cmp && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                        state <= ST_IDLE;
                    end else begin
                        if (first_cmp && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                        first_cmp       <= 1'b0;
                        vict_q          <= victim_way;
                        mem.mem_req_vld <= 1'b1;
                        if (victim_dirty) begin
                            mem.mem_req_wen <= 1'b1;
                            mem.mem_addr    <= {victim_tag, req_idx, {BOFF_W{1'b0}}};
                            mem.mem_wr_data <= victim_way ? blk1 : blk0;
                            state           <= ST_WB;
                        end else begin
                            mem.mem_req_wen <= 1'b0;
                            mem.mem_addr    <= {req_tag, req_idx, {BOFF_W{1'b0}}};
                            state           <= ST_ALLOC;
                        end
                    end
                end
                ST_WB: begin
                    if (mem.mem_req_done) begin
                        mem.mem_req_vld <= 1'b0;
                        state           <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    // Entered from WB with vld low: raise the fill request one cycle later.
                    if (!mem.mem_req_vld) begin
                        mem.mem_req_vld <= 1'b1;
                        mem.mem_req_wen <= 1'b0;
                        mem.mem_addr    <= {req_tag, req_idx, {BOFF_W{1'b0}}};
                    end else if (mem.mem_req_done) begin
                        mem.mem_req_vld <= 1'b0;
                        state           <= ST_CMP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_2way_wb.sv
// Scoreboard bench for cache_2way_wb: flat-memory reference model and a latency-varying memory responder.
module tb_cache_2way_wb;

    typedef struct {
        logic         wen;
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    logic clk;
    logic rst;
    logic [15:0] hit_cnt, miss_cnt;
    logic [3:0]  hit_cnt4, miss_cnt4;

    cache_cpu_if #(.ADDR_W(32), .WORD_W(32)) cpu_bus ();
    cache_mem_if #(.ADDR_W(32), .BLK_W(128)) mem_bus ();
    cache_cpu_if #(.ADDR_W(32), .WORD_W(32)) cpu4 ();
    cache_mem_if #(.ADDR_W(32), .BLK_W(128)) mem4 ();

    cache_2way_wb dut (
        .clk(clk), .rst(rst), .cpu(cpu_bus), .mem(mem_bus),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy sees identical stimulus, so it behaves cycle-for-cycle the same.
    cache_2way_wb #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cpu(cpu4), .mem(mem4),
        .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    assign cpu4.cpu_req_vld  = cpu_bus.cpu_req_vld;
    assign cpu4.cpu_req_wen  = cpu_bus.cpu_req_wen;
    assign cpu4.cpu_addr     = cpu_bus.cpu_addr;
    assign cpu4.cpu_wr_data  = cpu_bus.cpu_wr_data;
    assign mem4.mem_rd_data  = mem_bus.mem_rd_data;
    assign mem4.mem_req_done = mem_bus.mem_req_done;

    int vectors = 0;
    int miscompares = 0;
    int mem_lat_min = 1;
    int mem_lat_max = 3;
    int stab_err = 0;
    int gap_len = 0;
    int last_gap = 0;

    logic [31:0]  exp_q [$];
    mem_txn_t     mem_log [$];
    logic [127:0] mem_blocks [logic [31:0]];
    logic [31:0]  ref_words [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] init_block(input logic [31:0] a);
        logic [127:0] b;
        if (a == 32'h0000_1230) return 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        for (int i = 0; i < 4; i++) b[i*32 +: 32] = a + 32'h0101_0000 * (i + 1);
        return b;
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] a);
        if (mem_blocks.exists(a)) return mem_blocks[a];
        return init_block(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0]  wa;
        logic [127:0] blk;
        wa = {a[31:2], 2'b00};
        if (ref_words.exists(wa)) return ref_words[wa];
        blk = mem_block({a[31:4], 4'h0});
        return blk[a[3:2]*32 +: 32];
    endfunction

    // Memory responder: abandons the transaction if vld drops before completion.
    initial begin
        logic [31:0]  a;
        logic         w;
        logic [127:0] d;
        mem_txn_t     t;
        bit           abort;
        mem_bus.mem_req_done = 1'b0;
        mem_bus.mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req_vld === 1'b1) begin
                a = mem_bus.mem_addr;
                w = mem_bus.mem_req_wen;
                d = mem_bus.mem_wr_data;
                abort = 1'b0;
                repeat ($urandom_range(mem_lat_max, mem_lat_min)) begin
                    @(negedge clk);
                    if (mem_bus.mem_req_vld !== 1'b1) abort = 1'b1;
                    else if (!abort && (mem_bus.mem_addr !== a || mem_bus.mem_req_wen !== w ||
                             mem_bus.mem_wr_data !== d)) stab_err++;
                end
                if (!abort) begin
                    if (w) mem_blocks[a] = d;
                    else   mem_bus.mem_rd_data = mem_block(a);
                    mem_bus.mem_req_done = 1'b1;
                    t.wen = w;
                    t.addr = a;
                    t.data = w ? d : mem_bus.mem_rd_data;
                    mem_log.push_back(t);
                    @(negedge clk);
                    mem_bus.mem_req_done = 1'b0;
                end
            end
        end
    end

    // Length of the most recent run of low mem_req_vld before it rose again.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req_vld !== 1'b1) gap_len++;
            else begin
                if (gap_len > 0) last_gap = gap_len;
                gap_len = 0;
            end
        end
    end

    task automatic cpu_op(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat);
        logic [31:0] exp;
        bit got;
        exp_q.push_back(ref_read(addr));
        if (wen) ref_words[{addr[31:2], 2'b00}] = wd;
        @(negedge clk);
        cpu_bus.cpu_req_vld = 1'b1;
        cpu_bus.cpu_req_wen = wen;
        cpu_bus.cpu_addr    = addr;
        cpu_bus.cpu_wr_data = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (cpu_bus.cpu_done === 1'b1) got = 1'b1;
            cpu_bus.cpu_addr    = $urandom;
            cpu_bus.cpu_wr_data = $urandom;
            cpu_bus.cpu_req_wen = 1'($urandom_range(1, 0));
        end
        cpu_bus.cpu_req_vld = 1'b0;
        exp = exp_q.pop_front();
        vectors++;
        if (!got) begin
            $display("FAIL cpu_done_timeout addr=%h: no completion within %0d cycles", addr, lat);
            miscompares++;
        end else if (cpu_bus.cpu_rd_data !== exp) begin
            $display("FAIL rd_data addr=%h: got %h want %h", addr, cpu_bus.cpu_rd_data, exp);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cpu_bus.cpu_done, cpu_bus.cpu_rd_data, mem_bus.mem_req_vld, mem_bus.mem_req_wen,
             mem_bus.mem_addr, mem_bus.mem_wr_data, hit_cnt, miss_cnt, hit_cnt4, miss_cnt4} !== '0) begin
            $display("FAIL reset_outputs: done=%b vld=%b wen=%b addr=%h hit=%0d miss=%0d, want all 0",
                     cpu_bus.cpu_done, mem_bus.mem_req_vld, mem_bus.mem_req_wen, mem_bus.mem_addr,
                     hit_cnt, miss_cnt);
            miscompares++;
        end
        rst = 1'b1;
    endtask

    task automatic test_read_miss_hit();
        int lat;
        mem_log.delete();
        cpu_op(1'b0, 32'h0000_1238, 32'h0, lat);
        vectors++;
        if (mem_log.size() != 1 || mem_log[0].wen !== 1'b0 || mem_log[0].addr !== 32'h0000_1230) begin
            $display("FAIL t1_alloc: txns=%0d first_addr=%h, want 1 read at 00001230",
                     mem_log.size(), mem_log.size() > 0 ? mem_log[0].addr : 32'hx);
            miscompares++;
        end
        vectors++;
        if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
            $display("FAIL t1_counts: hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt);
            miscompares++;
        end
        mem_log.delete();
        cpu_op(1'b0, 32'h0000_1238, 32'h0, lat);
        vectors++;
        if (lat != 2 || mem_log.size() != 0) begin
            $display("FAIL t1_hit_latency: lat=%0d txns=%0d want 2/0", lat, mem_log.size());
            miscompares++;
        end
        vectors++;
        if (hit_cnt !== 16'd1) begin
            $display("FAIL t1_hit_cnt: got %0d want 1", hit_cnt);
            miscompares++;
        end
    endtask

    task automatic test_writeback();
        int lat;
        mem_log.delete();
        cpu_op(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, lat);
        vectors++;
        if (lat != 2 || mem_log.size() != 0) begin
            $display("FAIL t2_write_hit: lat=%0d txns=%0d want 2/0", lat, mem_log.size());
            miscompares++;
        end
        cpu_op(1'b0, 32'h0001_1234, 32'h0, lat);
        vectors++;
        if (mem_log.size() != 1 || mem_log[0].wen !== 1'b0 || mem_log[0].addr !== 32'h0001_1230) begin
            $display("FAIL t2_fill_way1: txns=%0d, want 1 read at 00011230", mem_log.size());
            miscompares++;
        end
        mem_log.delete();
        cpu_op(1'b0, 32'h0002_1234, 32'h0, lat);
        vectors++;
        if (mem_log.size() != 2 || mem_log[0].wen !== 1'b1 || mem_log[0].addr !== 32'h0000_1230 ||
            mem_log[0].data !== 128'h4444_4444_3333_3333_DEAD_BEEF_1111_1111) begin
            $display("FAIL t2_wb: txns=%0d wen=%b addr=%h data=%h, want WB 00001230 with DEADBEEF in word1",
                     mem_log.size(), mem_log.size() > 0 ? mem_log[0].wen : 1'bx,
                     mem_log.size() > 0 ? mem_log[0].addr : 32'hx,
                     mem_log.size() > 0 ? mem_log[0].data : 128'hx);
            miscompares++;
        end
        vectors++;
        if (mem_log.size() != 2 || mem_log[1].wen !== 1'b0 || mem_log[1].addr !== 32'h0002_1230) begin
            $display("FAIL t2_alloc_after_wb: txns=%0d, want read at 00021230 second", mem_log.size());
            miscompares++;
        end
        vectors++;
        if (last_gap != 1) begin
            $display("FAIL t2_vld_gap: got %0d cycles want 1", last_gap);
            miscompares++;
        end
    endtask

    task automatic test_lru();
        int lat;
        cpu_op(1'b0, 32'h0000_1230, 32'h0, lat);
        cpu_op(1'b0, 32'h0001_1230, 32'h0, lat);
        cpu_op(1'b0, 32'h0000_1230, 32'h0, lat);
        vectors++;
        if (lat != 2) begin
            $display("FAIL t3_a_hit: lat=%0d want 2", lat);
            miscompares++;
        end
        mem_log.delete();
        cpu_op(1'b0, 32'h0002_1230, 32'h0, lat);
        vectors++;
        if (mem_log.size() != 1 || mem_log[0].wen !== 1'b0 || mem_log[0].addr !== 32'h0002_1230) begin
            $display("FAIL t3_clean_evict: txns=%0d, want only a read at 00021230", mem_log.size());
            miscompares++;
        end
        cpu_op(1'b0, 32'h0000_1230, 32'h0, lat);
        vectors++;
        if (lat != 2 || mem_log.size() != 1) begin
            $display("FAIL t3_a_kept: lat=%0d txns=%0d want 2/1", lat, mem_log.size());
            miscompares++;
        end
    endtask

    task automatic test_write_allocate();
        int lat;
        mem_log.delete();
        cpu_op(1'b1, 32'h0000_5008, 32'h1234_5678, lat);
        vectors++;
        if (mem_log.size() != 1 || mem_log[0].wen !== 1'b0 || mem_log[0].addr !== 32'h0000_5000) begin
            $display("FAIL t4_alloc: txns=%0d, want 1 read at 00005000", mem_log.size());
            miscompares++;
        end
        cpu_op(1'b0, 32'h0000_5008, 32'h0, lat);
        vectors++;
        if (lat != 2 || mem_log.size() != 1) begin
            $display("FAIL t4_read_hit: lat=%0d txns=%0d want 2/1", lat, mem_log.size());
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_alloc();
        int lat;
        int n;
        mem_lat_min = 8;
        mem_lat_max = 8;
        @(negedge clk);
        cpu_bus.cpu_req_vld = 1'b1;
        cpu_bus.cpu_req_wen = 1'b0;
        cpu_bus.cpu_addr    = 32'h0003_4560;
        n = 0;
        while (mem_bus.mem_req_vld !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (mem_bus.mem_req_vld !== 1'b1 || mem_bus.mem_req_wen !== 1'b0) begin
            $display("FAIL t5_alloc_start: vld=%b wen=%b want 1/0", mem_bus.mem_req_vld, mem_bus.mem_req_wen);
            miscompares++;
        end
        rst = 1'b0;
        cpu_bus.cpu_req_vld = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_bus.mem_req_vld !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || hit_cnt4 !== 4'd0) begin
            $display("FAIL t5_reset_abort: vld=%b hit=%0d miss=%0d want 0/0/0",
                     mem_bus.mem_req_vld, hit_cnt, miss_cnt);
            miscompares++;
        end
        rst = 1'b1;
        ref_words.delete();
        mem_lat_min = 1;
        mem_lat_max = 3;
        repeat (12) @(negedge clk);
        mem_log.delete();
        cpu_op(1'b0, 32'h0000_5008, 32'h0, lat);
        vectors++;
        if (mem_log.size() != 1 || mem_log[0].addr !== 32'h0000_5000 || miss_cnt !== 16'd1) begin
            $display("FAIL t5_miss_after_reset: txns=%0d miss=%0d want 1/1", mem_log.size(), miss_cnt);
            miscompares++;
        end
    endtask

    task automatic test_saturate();
        int lat;
        logic [15:0] h0;
        h0 = hit_cnt;
        repeat (20) cpu_op(1'b0, 32'h0000_5008, 32'h0, lat);
        vectors++;
        if (hit_cnt4 !== 4'd15 || hit_cnt !== h0 + 16'd20) begin
            $display("FAIL t6_saturate: narrow=%0d wide=%0d want 15/%0d", hit_cnt4, hit_cnt, h0 + 16'd20);
            miscompares++;
        end
        repeat (3) cpu_op(1'b0, 32'h0000_5008, 32'h0, lat);
        vectors++;
        if (hit_cnt4 !== 4'd15 || miss_cnt4 !== 4'(miss_cnt)) begin
            $display("FAIL t6_hold: narrow hit=%0d miss=%0d want 15/%0d", hit_cnt4, miss_cnt4, miss_cnt);
            miscompares++;
        end
    endtask

    task automatic test_bus_stability();
        vectors++;
        if (stab_err != 0) begin
            $display("FAIL mem_bus_stable: %0d changes while outstanding, want 0", stab_err);
            miscompares++;
        end
    endtask

    initial begin
        rst = 1'b0;
        cpu_bus.cpu_req_vld = 1'b0;
        cpu_bus.cpu_req_wen = 1'b0;
        cpu_bus.cpu_addr    = '0;
        cpu_bus.cpu_wr_data = '0;
        test_reset();
        test_read_miss_hit();
        test_writeback();
        test_lru();
        test_write_allocate();
        test_reset_mid_alloc();
        test_saturate();
        test_bus_stability();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
